// File: rtl/axis_frame_len_adjust_pkg.sv
// Shared definitions for the AXI-Stream frame length adjuster:
// the FSM state encoding and the saturating-counter ceiling helper.
package axis_frame_len_adjust_pkg;

    typedef enum logic [1:0] {
        ST_TRANSFER = 2'd0,
        ST_PAD      = 2'd1,
        ST_DROP     = 2'd2
    } adj_state_e;

    localparam int CNT_MAX_WIDTH = 32;

    // All-ones value of a w-bit saturating counter (w up to CNT_MAX_WIDTH).
    function automatic logic [CNT_MAX_WIDTH-1:0] sat_max(input int w);
        logic [CNT_MAX_WIDTH-1:0] v;
        v = {CNT_MAX_WIDTH{1'b0}};
        for (int i = 0; i < CNT_MAX_WIDTH; i++) begin
            v[i] = (i < w);
        end
        return v;
    endfunction

endpackage

// File: rtl/axis_frame_len_adjust.sv
// AXI-Stream frame length adjuster: pads short frames with zero beats, truncates
// long frames and drops their tail, and reports one status pulse per input frame.
module axis_frame_len_adjust
    import axis_frame_len_adjust_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int ID_WIDTH    = 8,
    parameter int DEST_WIDTH  = 8,
    parameter int USER_WIDTH  = 1,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser,

    input  logic [LEN_WIDTH-1:0]  length_min,
    input  logic [LEN_WIDTH-1:0]  length_max,

    output logic                  status_valid,
    output logic                  status_frame_pad,
    output logic                  status_frame_truncate,
    output logic [LEN_WIDTH-1:0]  status_frame_length
);

    localparam logic [LEN_WIDTH-1:0] CNT_MAX = LEN_WIDTH'(sat_max(LEN_WIDTH));

    adj_state_e            state_r, state_nxt_s;
    logic [LEN_WIDTH-1:0]  cnt_r, cnt_nxt_s, min_r, min_nxt_s, max_r, max_nxt_s;
    logic [LEN_WIDTH-1:0]  pad_rem_r, pad_rem_nxt_s;
    logic [LEN_WIDTH-1:0]  beat_idx_s, in_min_s, cur_min_s, cur_max_s;
    logic                  first_s, out_ready_s, s_ready_s, accept_s, side_load_s;
    logic [ID_WIDTH-1:0]   id_r;
    logic [DEST_WIDTH-1:0] dest_r;
    logic [USER_WIDTH-1:0] user_r;

    logic                  emit_s, emit_last_s;
    logic [DATA_WIDTH-1:0] emit_data_s;
    logic [KEEP_WIDTH-1:0] emit_keep_s;
    logic [ID_WIDTH-1:0]   emit_id_s;
    logic [DEST_WIDTH-1:0] emit_dest_s;
    logic [USER_WIDTH-1:0] emit_user_s;

    logic                  m_valid_r, m_last_r;
    logic [DATA_WIDTH-1:0] m_data_r;
    logic [KEEP_WIDTH-1:0] m_keep_r;
    logic [ID_WIDTH-1:0]   m_id_r;
    logic [DEST_WIDTH-1:0] m_dest_r;
    logic [USER_WIDTH-1:0] m_user_r;

    logic                  status_fire_s, status_pad_s, status_trunc_s;
    logic                  status_valid_r, status_pad_r, status_trunc_r;
    logic [LEN_WIDTH-1:0]  status_len_r;

    // Limits come live from the ports on a frame's first beat, latched otherwise.
    assign first_s     = (cnt_r == {LEN_WIDTH{1'b0}});
    assign in_min_s    = ((length_max != {LEN_WIDTH{1'b0}}) && (length_min > length_max))
                         ? length_max : length_min;
    assign cur_min_s   = first_s ? in_min_s : min_r;
    assign cur_max_s   = first_s ? length_max : max_r;
    assign beat_idx_s  = (cnt_r == CNT_MAX) ? CNT_MAX : cnt_r + LEN_WIDTH'(1);
    assign out_ready_s = m_axis_tready || !m_valid_r;
    assign accept_s    = s_axis_tvalid && s_ready_s;

    // Next-state, beat emission and status decode.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        min_nxt_s      = min_r;
        max_nxt_s      = max_r;
        pad_rem_nxt_s  = pad_rem_r;
        s_ready_s      = 1'b0;
        side_load_s    = 1'b0;
        emit_s         = 1'b0;
        emit_last_s    = 1'b0;
        emit_data_s    = {DATA_WIDTH{1'b0}};
        emit_keep_s    = {KEEP_WIDTH{1'b1}};
        emit_id_s      = id_r;
        emit_dest_s    = dest_r;
        emit_user_s    = user_r;
        status_fire_s  = 1'b0;
        status_pad_s   = 1'b0;
        status_trunc_s = 1'b0;
        case (state_r)
            ST_TRANSFER: begin
                s_ready_s = out_ready_s;
                if (accept_s) begin
                    emit_s      = 1'b1;
                    side_load_s = 1'b1;
                    emit_data_s = s_axis_tdata;
                    emit_keep_s = KEEP_ENABLE ? s_axis_tkeep : {KEEP_WIDTH{1'b1}};
                    emit_id_s   = s_axis_tid;
                    emit_dest_s = s_axis_tdest;
                    emit_user_s = s_axis_tuser;
                    if (first_s) begin
                        min_nxt_s = in_min_s;
                        max_nxt_s = length_max;
                    end else begin
                        min_nxt_s = min_r;
                        max_nxt_s = max_r;
                    end
                    if ((cur_max_s != {LEN_WIDTH{1'b0}}) && (beat_idx_s == cur_max_s) && !s_axis_tlast) begin
                        emit_last_s = 1'b1;
                        cnt_nxt_s   = beat_idx_s;
                        state_nxt_s = ST_DROP;
                    end else if (s_axis_tlast && (beat_idx_s < cur_min_s)) begin
                        emit_last_s   = 1'b0;
                        cnt_nxt_s     = {LEN_WIDTH{1'b0}};
                        pad_rem_nxt_s = cur_min_s - beat_idx_s;
                        state_nxt_s   = ST_PAD;
                        status_fire_s = 1'b1;
                        status_pad_s  = 1'b1;
                    end else if (s_axis_tlast) begin
                        emit_last_s   = 1'b1;
                        cnt_nxt_s     = {LEN_WIDTH{1'b0}};
                        status_fire_s = 1'b1;
                    end else begin
                        emit_last_s = 1'b0;
                        cnt_nxt_s   = beat_idx_s;
                    end
                end else begin
                    emit_s = 1'b0;
                end
            end
            ST_PAD: begin
                s_ready_s = 1'b0;
                if (out_ready_s) begin
                    emit_s = 1'b1;
                    if (pad_rem_r == LEN_WIDTH'(1)) begin
                        emit_last_s   = 1'b1;
                        pad_rem_nxt_s = {LEN_WIDTH{1'b0}};
                        state_nxt_s   = ST_TRANSFER;
                    end else begin
                        emit_last_s   = 1'b0;
                        pad_rem_nxt_s = pad_rem_r - LEN_WIDTH'(1);
                    end
                end else begin
                    emit_s = 1'b0;
                end
            end
            ST_DROP: begin
                s_ready_s = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    cnt_nxt_s      = {LEN_WIDTH{1'b0}};
                    state_nxt_s    = ST_TRANSFER;
                    status_fire_s  = 1'b1;
                    status_trunc_s = 1'b1;
                end else if (s_axis_tvalid) begin
                    cnt_nxt_s = beat_idx_s;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_TRANSFER;
            end
        endcase
    end

    // FSM state, frame counters, side-band hold and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_TRANSFER;
            cnt_r          <= {LEN_WIDTH{1'b0}};
            min_r          <= {LEN_WIDTH{1'b0}};
            max_r          <= {LEN_WIDTH{1'b0}};
            pad_rem_r      <= {LEN_WIDTH{1'b0}};
            id_r           <= {ID_WIDTH{1'b0}};
            dest_r         <= {DEST_WIDTH{1'b0}};
            user_r         <= {USER_WIDTH{1'b0}};
            status_valid_r <= 1'b0;
            status_pad_r   <= 1'b0;
            status_trunc_r <= 1'b0;
            status_len_r   <= {LEN_WIDTH{1'b0}};
        end else begin
            state_r        <= state_nxt_s;
            cnt_r          <= cnt_nxt_s;
            min_r          <= min_nxt_s;
            max_r          <= max_nxt_s;
            pad_rem_r      <= pad_rem_nxt_s;
            status_valid_r <= status_fire_s;
            if (side_load_s) begin
                id_r   <= s_axis_tid;
                dest_r <= s_axis_tdest;
                user_r <= s_axis_tuser;
            end
            if (status_fire_s) begin
                status_pad_r   <= status_pad_s;
                status_trunc_r <= status_trunc_s;
                status_len_r   <= beat_idx_s;
            end
        end
    end

    // Single output register stage; holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_data_r  <= {DATA_WIDTH{1'b0}};
            m_keep_r  <= {KEEP_WIDTH{1'b0}};
            m_id_r    <= {ID_WIDTH{1'b0}};
            m_dest_r  <= {DEST_WIDTH{1'b0}};
            m_user_r  <= {USER_WIDTH{1'b0}};
        end else if (out_ready_s) begin
            m_valid_r <= emit_s;
            if (emit_s) begin
                m_last_r <= emit_last_s;
                m_data_r <= emit_data_s;
                m_keep_r <= emit_keep_s;
                m_id_r   <= emit_id_s;
                m_dest_r <= emit_dest_s;
                m_user_r <= emit_user_s;
            end
        end
    end

    assign s_axis_tready         = s_ready_s;
    assign m_axis_tvalid         = m_valid_r;
    assign m_axis_tlast          = m_last_r;
    assign m_axis_tdata          = m_data_r;
    assign m_axis_tkeep          = m_keep_r;
    assign m_axis_tid            = m_id_r;
    assign m_axis_tdest          = m_dest_r;
    assign m_axis_tuser          = m_user_r;
    assign status_valid          = status_valid_r;
    assign status_frame_pad      = status_pad_r;
    assign status_frame_truncate = status_trunc_r;
    assign status_frame_length   = status_len_r;

endmodule

// File: tb/tb_axis_frame_len_adjust.sv
// Self-checking bench for axis_frame_len_adjust: table-driven frames, directed
// corner sequences and random backpressure, checked against a beat/status scoreboard.
module tb_axis_frame_len_adjust;

    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    s_tdata;
    logic [0:0]    s_tkeep;
    logic          s_tvalid, s_tready, s_tlast, s_tuser;
    logic [7:0]    s_tid, s_tdest;
    logic [7:0]    m_tdata;
    logic [0:0]    m_tkeep;
    logic          m_tvalid, m_tready, m_tlast, m_tuser;
    logic [7:0]    m_tid, m_tdest;
    logic [LW-1:0] length_min, length_max;
    logic          status_valid, status_pad, status_trunc;
    logic [LW-1:0] status_len;

    always #5 clk = ~clk;

    axis_frame_len_adjust #(
        .DATA_WIDTH(8), .KEEP_ENABLE(1'b0), .KEEP_WIDTH(1), .ID_WIDTH(8),
        .DEST_WIDTH(8), .USER_WIDTH(1), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
        .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
        .length_min(length_min), .length_max(length_max),
        .status_valid(status_valid), .status_frame_pad(status_pad),
        .status_frame_truncate(status_trunc), .status_frame_length(status_len)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] id;
        logic [7:0] dest;
        logic       user;
    } beat_t;

    typedef struct {
        logic          pad;
        logic          trunc;
        logic [LW-1:0] len;
    } stat_t;

    typedef struct {
        int         min;
        int         max;
        int         len;
        logic [7:0] base;
        logic       user;
        int         out_len;
        bit         pad;
        bit         trunc;
    } vec_t;

    beat_t exp_q[$];
    stat_t stat_q[$];
    int    pass_cnt = 0;
    int    chk_cnt  = 0;
    bit    sb_en = 1'b1;
    bit    rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Output-side ready generator
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Monitor: sampled on the falling edge, i.e. the state the next rising edge sees
    initial begin
        beat_t b, held, e;
        stat_t s;
        bit    held_v;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            b = '{m_tdata, m_tlast, m_tid, m_tdest, m_tuser};
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    check("stall_valid_held", m_tvalid, 1);
                    check("stall_beat_stable", b == held, 1);
                end
                held_v = m_tvalid && !m_tready;
                held   = b;
                if (m_tvalid && m_tready && sb_en) begin
                    check("extra_beat", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("beat_data", m_tdata, e.data);
                        check("beat_last", m_tlast, e.last);
                        check("beat_id",   m_tid,   e.id);
                        check("beat_dest", m_tdest, e.dest);
                        check("beat_user", m_tuser, e.user);
                        check("beat_keep", m_tkeep, 1);
                    end
                end
                if (status_valid && sb_en) begin
                    check("extra_status", stat_q.size() > 0, 1);
                    if (stat_q.size() > 0) begin
                        s = stat_q.pop_front();
                        check("status_pad",   status_pad,   s.pad);
                        check("status_trunc", status_trunc, s.trunc);
                        check("status_len",   status_len,   s.len);
                    end
                end
            end
        end
    end

    // Drive one frame (stop_after < len abandons it) and queue its expected output
    task automatic send_frame(input int len, input int stop_after, input logic [7:0] base,
                              input logic [7:0] id, input logic user_v, input int out_len,
                              input bit pad, input bit trunc, input bit chg_mid,
                              output int stalls);
        beat_t e;
        stat_t s;
        int    tmo;
        stalls = 0;
        if (sb_en) begin
            for (int i = 0; i < out_len; i++) begin
                e.data = (i < len) ? 8'(base + i) : 8'h00;
                e.last = (i == out_len - 1);
                e.id   = id;
                e.dest = ~id;
                e.user = user_v;
                exp_q.push_back(e);
            end
            s.pad = pad; s.trunc = trunc; s.len = LW'(len);
            stat_q.push_back(s);
        end
        for (int i = 0; i < stop_after; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(base + i);
            s_tlast  = (i == len - 1);
            s_tid    = id;
            s_tdest  = ~id;
            s_tuser  = user_v;
            tmo = 0;
            forever begin
                @(negedge clk);
                if (s_tready) break;
                stalls++;
                tmo++;
                if (tmo > 200) begin
                    check("accept_timeout", tmo, 0);
                    break;
                end
            end
            @(posedge clk);
            #1;
            if (chg_mid && i == 0) begin
                length_min = LW'(1);
                length_max = LW'(1);
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || stat_q.size() != 0) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_beats_left"}, exp_q.size(), 0);
        check({tag, "_status_left"}, stat_q.size(), 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_status_valid", status_valid, 0);
        check("rst_s_tready", s_tready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_status", status_valid, 0);
        end
        exp_q.delete();
        stat_q.delete();
        @(posedge clk);
        #1;
    endtask

    vec_t       vecs[11];
    int         stalls, len, ol;
    bit         pd, tr;
    logic [7:0] data_seq;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{4, 8, 6, 8'h10, 1'b0, 6, 1'b0, 1'b0};
        vecs[1]  = '{4, 8, 2, 8'hA1, 1'b1, 4, 1'b1, 1'b0};
        vecs[2]  = '{0, 3, 7, 8'h30, 1'b0, 3, 1'b0, 1'b1};
        vecs[3]  = '{5, 3, 1, 8'h40, 1'b1, 3, 1'b1, 1'b0};
        vecs[4]  = '{0, 0, 5, 8'h50, 1'b0, 5, 1'b0, 1'b0};
        vecs[5]  = '{1, 0, 1, 8'h60, 1'b0, 1, 1'b0, 1'b0};
        vecs[6]  = '{4, 4, 4, 8'h70, 1'b1, 4, 1'b0, 1'b0};
        vecs[7]  = '{0, 1, 3, 8'h80, 1'b0, 1, 1'b0, 1'b1};
        vecs[8]  = '{3, 8, 8, 8'h90, 1'b1, 8, 1'b0, 1'b0};
        vecs[9]  = '{6, 0, 5, 8'hB0, 1'b0, 6, 1'b1, 1'b0};
        vecs[10] = '{2, 5, 1, 8'hC0, 1'b1, 2, 1'b1, 1'b0};

        rst = 1'b1;
        s_tdata = 8'h00; s_tkeep = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0;
        s_tid = 8'h00; s_tdest = 8'h00; s_tuser = 1'b0;
        length_min = LW'(0); length_max = LW'(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tvalid", m_tvalid, 0);
        check("reset_status_valid", status_valid, 0);
        check("reset_status_pad", status_pad, 0);
        check("reset_status_trunc", status_trunc, 0);
        check("reset_status_len", status_len, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Table of frames, back to back
        for (int i = 0; i < 11; i++) begin
            length_min = LW'(vecs[i].min);
            length_max = LW'(vecs[i].max);
            send_frame(vecs[i].len, vecs[i].len, vecs[i].base, 8'(i + 1), vecs[i].user,
                       vecs[i].out_len, vecs[i].pad, vecs[i].trunc, 1'b0, stalls);
        end
        drain("table");

        // Input is held off for exactly the two pad beats
        length_min = LW'(4); length_max = LW'(8);
        send_frame(2, 2, 8'hA1, 8'h21, 1'b1, 4, 1'b1, 1'b0, 1'b0, stalls);
        send_frame(5, 5, 8'hD0, 8'h22, 1'b0, 5, 1'b0, 1'b0, 1'b0, stalls);
        check("pad_stall_cycles", stalls, 2);
        drain("padstall");

        // Limits changed mid-frame must not affect the frame in flight
        length_min = LW'(4); length_max = LW'(8);
        send_frame(2, 2, 8'hE0, 8'h23, 1'b0, 4, 1'b1, 1'b0, 1'b1, stalls);
        drain("midchange");

        // Random backpressure, random lengths
        rand_ready = 1'b1;
        length_min = LW'(4); length_max = LW'(12);
        data_seq = 8'h00;
        for (int f = 0; f < 200; f++) begin
            len = $urandom_range(1, 20);
            pd = (len < 4);
            tr = (len > 12);
            ol = tr ? 12 : (pd ? 4 : len);
            send_frame(len, len, data_seq, 8'($urandom), 1'($urandom_range(0, 1)),
                       ol, pd, tr, 1'b0, stalls);
            data_seq = 8'(data_seq + len);
        end
        drain("random");
        rand_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset while padding
        sb_en = 1'b0;
        length_min = LW'(10); length_max = LW'(0);
        send_frame(1, 1, 8'h11, 8'h31, 1'b0, 10, 1'b1, 1'b0, 1'b0, stalls);
        repeat (2) @(posedge clk);
        #1;
        pulse_reset();
        sb_en = 1'b1;
        length_min = LW'(4); length_max = LW'(8);
        send_frame(6, 6, 8'h55, 8'h32, 1'b1, 6, 1'b0, 1'b0, 1'b0, stalls);
        drain("after_rst_pad");

        // Reset while dropping
        sb_en = 1'b0;
        length_min = LW'(0); length_max = LW'(3);
        send_frame(10, 6, 8'h66, 8'h33, 1'b0, 3, 1'b0, 1'b1, 1'b0, stalls);
        pulse_reset();
        sb_en = 1'b1;
        length_min = LW'(4); length_max = LW'(8);
        send_frame(6, 6, 8'h77, 8'h34, 1'b0, 6, 1'b0, 1'b0, 1'b0, stalls);
        send_frame(3, 3, 8'h88, 8'h35, 1'b1, 4, 1'b1, 1'b0, 1'b0, stalls);
        drain("after_rst_drop");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/axis_frame_len_adjust.md
# axis_frame_len_adjust

AXI-Stream frame length adjuster that sits directly downstream of the frame FIFO and consumes its output. Frames shorter than a runtime minimum are padded with zero beats. Frames longer than a runtime maximum are truncated, and the remaining input beats are discarded. One status pulse per frame reports the action taken and the input length.

## Interface
- DATA_WIDTH, 8, tdata width
- KEEP_ENABLE, DATA_WIDTH>8, tkeep present
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- ID_WIDTH, 8, tid width
- DEST_WIDTH, 8, tdest width
- USER_WIDTH, 1, tuser width
- LEN_WIDTH, 16, width of length inputs, beat counter and status length

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  in (tready out)  per parameters  input stream
- m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser  out (tready in)  per parameters  output stream
- length_min  in  LEN_WIDTH  minimum frame length in beats; values 0 and 1 disable padding
- length_max  in  LEN_WIDTH  maximum frame length in beats; value 0 disables truncation
- status_valid  out  1  one-cycle pulse, once per input frame
- status_frame_pad  out  1  the frame was padded
- status_frame_truncate  out  1  the frame was truncated
- status_frame_length  out  LEN_WIDTH  input beat count, saturating at all-ones

## Operation
- Effective limits:
  - length_min and length_max are sampled on the first beat of each frame and held until that frame ends.
  - If length_max≠0 and length_min>length_max, the effective minimum equals length_max.
- The beat counter holds the 1-based index of the current input beat. It resets to 0 at frame end and saturates (no wrap).
- States: TRANSFER, PAD, DROP. Reset state is TRANSFER.
- TRANSFER (s_axis_tready = output register can accept):
  - Beats are copied unchanged.
  - Input tlast with count n < min: the beat is emitted with tlast=0, then go to PAD with min−n beats remaining.
  - count == max with tlast=0: the beat is emitted with tlast=1, then go to DROP.
  - count == max with tlast=1: normal end of frame, not a truncation.
  - If both conditions could apply, truncation wins.
- PAD (s_axis_tready=0):
  - Each pad beat carries tdata=0 and tkeep=all-ones.
  - tid, tdest and tuser are copied from the last input beat.
  - The final pad beat has tlast=1, then go to TRANSFER.
- DROP (s_axis_tready=1):
  - Input beats are discarded and nothing is emitted.
  - On input tlast, go to TRANSFER.
- Status:
  - status_valid pulses on the cycle after the input tlast beat is accepted in TRANSFER or DROP.
  - The pulse fires regardless of whether PAD is still in progress.
  - All status fields are valid with the pulse and held until the next pulse.

## Timing
- The output is a single register stage. Latency is 1 cycle from input acceptance to m_axis_tvalid.
- The output register loads when m_axis_tready || !m_axis_tvalid.
- Full throughput: 1 beat/cycle in TRANSFER, PAD and DROP with m_axis_tready held at 1.
- Back-to-back frames add no idle cycles. A new frame's first beat may be accepted on the cycle after PAD emits its final beat.
- Reset values:
  - Outputs: m_axis_tvalid=0, status_valid=0, status_frame_pad=0, status_frame_truncate=0, status_frame_length=0.
  - Internal: state=TRANSFER, counter=0.
- Reset mid-frame abandons the frame with no status pulse. The next beat is treated as a first beat.
- Changes to length_min/length_max mid-frame have no effect until the next frame.
- Under backpressure (m_axis_tready=0), m_axis_* is held stable while tvalid=1, per AXI-Stream rules.

## Structure
- A shared axis package holds:
  - the state enum (TRANSFER, PAD, DROP);
  - the helper constant for the saturating counter max.
- No sub-module. The output register is inline. The ID/DEST/USER side-band holding register is local.

## Test plan
- min=4, max=8, 6-beat frame, m_axis_tready=1:
  - 6 beats unchanged, tlast on beat 6.
  - Status: pad=0, trunc=0, len=6.
- min=4, 2-beat frame data 0xA1,0xA2, tuser=1:
  - Output A1, A2, 00, 00, with tlast only on beat 4 and tuser=1 on the pad beats.
  - s_axis_tready=0 for 2 cycles.
  - Status: pad=1, len=2.
- max=3, 7-beat frame:
  - 3 beats emitted, beat 3 with tlast=1.
  - Beats 4–7 are accepted and dropped.
  - Status: trunc=1, len=7.
- min=5, max=3, 1-beat frame:
  - 3 output beats (effective min=3).
  - Status: pad=1.
- Random m_axis_tready (50%) over 200 frames with random lengths 1–20, min=4, max=12:
  - Output frame lengths are within 4..12.
  - Data ordering is preserved.
  - No beat changes while stalled.
- rst asserted mid-PAD and mid-DROP:
  - m_axis_tvalid=0 on the next cycle and no status pulse.
  - The next frame is processed correctly from beat 1.
